// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined IEEE-754 multiplier with round-to-nearest-even.
// Subnormal inputs are flushed to zero. Both sides use a valid/ready handshake.
module fp_mul_pipe #(
    parameter int PRECISION = 32,
    parameter int EXPONENT  = 8,
    parameter int FRACTION  = 23
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] a_operand,
    input  logic [PRECISION-1:0] b_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] result,
    output logic [3:0]           flags
);
    localparam int EW = EXPONENT + 2;
    localparam int MW = FRACTION + 1;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXPONENT - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXPONENT) - 1);
    localparam logic [PRECISION-1:0] QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

    if (PRECISION != 1 + EXPONENT + FRACTION) begin : g_bad_params
        $error("fp_mul_pipe: PRECISION must equal 1+EXPONENT+FRACTION");
    end

    logic v1, v2, v3, load1, load2, load3;
    logic s1, s2, nan1, nan2, inv1, inv2, inf1, inf2, zero1, zero2;
    logic signed [EW-1:0] e1, e2;
    logic [MW-1:0] ma1, mb1;
    logic [2*MW-1:0] p2;

    // A stage may load when it is empty or its content moves on this cycle.
    assign load3 = !v3 || out_ready;
    assign load2 = !v2 || load3;
    assign load1 = !v1 || load2;
    assign in_ready = load1;
    assign out_valid = v3;

    logic [EXPONENT-1:0] ea, eb;
    logic [FRACTION-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb, sna, snb, zi;

    assign ea = a_operand[PRECISION-2:FRACTION];
    assign eb = b_operand[PRECISION-2:FRACTION];
    assign fa = a_operand[FRACTION-1:0];
    assign fb = b_operand[FRACTION-1:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea && fa == '0;
    assign ib = &eb && fb == '0;
    assign na = &ea && fa != '0;
    assign nb = &eb && fb != '0;
    assign sna = na && !fa[FRACTION-1];
    assign snb = nb && !fb[FRACTION-1];
    assign zi = (za && ib) || (zb && ia);

    logic msb, guard, sticky, rnd, carry, ovf, unf;
    logic [2*MW-1:0] sh;
    logic [MW:0] mant_r;
    logic [FRACTION-1:0] frac;
    logic signed [EW-1:0] e_r;
    logic [PRECISION-1:0] inf_w, zero_w, res_w;
    logic [3:0] flags_w;

    always_comb begin
        msb = p2[2*MW-1];
        sh = msb ? p2 : p2 << 1;
        guard = sh[FRACTION];
        sticky = |sh[FRACTION-1:0];
        rnd = guard && (sticky || sh[MW]);
        mant_r = {1'b0, sh[2*MW-1:MW]} + (MW+1)'(rnd);
        carry = mant_r[MW];
        frac = carry ? mant_r[MW-1:1] : mant_r[FRACTION-1:0];
        e_r = e2 + EW'(msb) + EW'(carry);
        ovf = e_r >= EMAX;
        unf = e_r[EW-1] || e_r == '0;
        inf_w = {s2, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        zero_w = {s2, {(PRECISION-1){1'b0}}};
        res_w = nan2 ? QNAN : inf2 ? inf_w : zero2 ? zero_w : ovf ? inf_w : unf ? zero_w
              : {s2, e_r[EXPONENT-1:0], frac};
        flags_w = nan2 ? {inv2, 3'b000} : (inf2 || zero2) ? 4'b0000 : ovf ? 4'b0101
                : unf ? 4'b0011 : {3'b000, guard || sticky};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {v1, v2, v3, s1, s2, nan1, nan2, inv1, inv2, inf1, inf2, zero1, zero2} <= '0;
            e1 <= '0;
            e2 <= '0;
            ma1 <= '0;
            mb1 <= '0;
            p2 <= '0;
            result <= '0;
            flags <= '0;
        end else begin
            if (load1) v1 <= in_valid;
            if (load1 && in_valid) begin
                s1 <= a_operand[PRECISION-1] ^ b_operand[PRECISION-1];
                e1 <= EW'(ea) + EW'(eb) - BIAS;
                ma1 <= {1'b1, fa};
                mb1 <= {1'b1, fb};
                nan1 <= na || nb || zi;
                inv1 <= sna || snb || zi;
                inf1 <= ia || ib;
                zero1 <= za || zb;
            end
            if (load2) v2 <= v1;
            if (load2 && v1) begin
                s2 <= s1;
                e2 <= e1;
                p2 <= (2*MW)'(ma1) * (2*MW)'(mb1);
                nan2 <= nan1;
                inv2 <= inv1;
                inf2 <= inf1;
                zero2 <= zero1;
            end
            if (load3) v3 <= v2;
            if (load3 && v2) begin
                result <= res_w;
                flags <= flags_w;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed binary32 bench for fp_mul_pipe; expected results
// queue up at input handshake and are checked when the DUT hands them out.
module tb_fp_mul_pipe;
    logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [31:0] a_operand = 0, b_operand = 0, result;
    logic [3:0] flags;
    int cyc = 0, n_cmp = 0, n_bad = 0, n_out = 0, n0;

    typedef struct { logic [31:0] r; logic [3:0] f; int c; bit lat; } exp_t;
    exp_t sb[$];
    exp_t e;
    logic held = 0;
    logic [31:0] held_r;
    logic [3:0] held_f;

    logic [31:0] da [18] = '{32'h3F000000, 32'hC0200000, 32'h40500000, 32'h41200000, 32'h3F800001,
                             32'h3F918E00, 32'h00000000, 32'h7F800001, 32'hFF800000, 32'h7F000000,
                             32'h00800000, 32'h00000001, 32'hFFC12345, 32'h80000000, 32'h3F800000,
                             32'hFF000000, 32'h3F800000, 32'h7F800000};
    logic [31:0] db [18] = '{32'hBEE00000, 32'hBFC00000, 32'hBFC00000, 32'h3F000000, 32'h3F800001,
                             32'h3FE12000, 32'h7F800000, 32'h3F800000, 32'h40000000, 32'h7F000000,
                             32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F800000,
                             32'h7F000000, 32'h7FA00000, 32'h7FC00000};
    logic [31:0] dr [18] = '{32'hBE600000, 32'h40700000, 32'hC09C0000, 32'h40A00000, 32'h3F800002,
                             32'h40000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                             32'h00000000, 32'h00000000, 32'h7FC00000, 32'h80000000, 32'h7F800000,
                             32'hFF800000, 32'h7FC00000, 32'h7FC00000};
    logic [3:0] df [18] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h8, 4'h0,
                            4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h8, 4'h0};
    logic [31:0] ba [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] br [6] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

    fp_mul_pipe #(.PRECISION(32), .EXPONENT(8), .FRACTION(23)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the operands.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [3:0] f, input bit lat);
        int n = 0;
        a_operand = a;
        b_operand = b;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        if (in_ready) sb.push_back('{r, f, cyc, lat});
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) held = 0;
            else begin
                if (held) begin
                    check("stall_valid", {31'b0, out_valid}, 32'd1);
                    check("stall_result", result, held_r);
                    check("stall_flags", {28'b0, flags}, {28'b0, held_f});
                end
                held = out_valid && !out_ready;
                held_r = result;
                held_f = flags;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) check("spurious_output", {31'b0, out_valid}, 32'd0);
                    else begin
                        e = sb.pop_front();
                        check("result", result, e.r);
                        check("flags", {28'b0, flags}, {28'b0, e.f});
                        if (e.lat) check("latency", 32'(cyc - e.c), 32'd3);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'b0, flags}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        a_operand = 32'h3F800000;
        b_operand = 32'h40000000;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        reset_n = 1;

        for (int i = 0; i < 18; i++) send(da[i], db[i], dr[i], df[i], 1'b1);
        drain();

        n0 = n_out;
        fork
            for (int j = 0; j < 6; j++) send(ba[j], 32'h40000000, br[j], 4'h0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("full_in_ready", {31'b0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();
        check("bp_delivered", 32'(n_out - n0), 32'd6);

        send(32'h40400000, 32'h40400000, 32'h41100000, 4'h0, 1'b0);
        send(32'h40800000, 32'h40800000, 32'h41800000, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        reset_n = 0;
        #1;
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1;
        send(32'h40A00000, 32'h40A00000, 32'h41C80000, 4'h0, 1'b1);
        drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", {31'b0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
